// File: rtl/operand_fetch_stage.sv
// Register-fetch stage: GPR file plus HI/LO, rs/rt decode, and a one-entry
// valid/ready output register feeding the ALU with write-first bypass and stall refresh.
module operand_fetch_stage #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 5
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [31:0]           in_instr,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [31:0]           out_instr,
    output logic [DATA_WIDTH-1:0] out_in0,
    output logic [DATA_WIDTH-1:0] out_in1,
    input  logic                  flush,
    input  logic                  wb_en,
    input  logic [ADDR_WIDTH-1:0] wb_addr,
    input  logic [DATA_WIDTH-1:0] wb_data,
    input  logic                  hilo_we,
    input  logic [DATA_WIDTH-1:0] hi_wdata,
    input  logic [DATA_WIDTH-1:0] lo_wdata
);

    localparam int unsigned NREG = 2 ** ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] gpr_q [NREG];
    logic [DATA_WIDTH-1:0] hi_q, lo_q;

    logic                  out_valid_q, out_valid_d;
    logic [31:0]           out_instr_q, out_instr_d;
    logic [DATA_WIDTH-1:0] out_in0_q, out_in0_d;
    logic [DATA_WIDTH-1:0] out_in1_q, out_in1_d;

    logic [ADDR_WIDTH-1:0] rs, rt, h_rs, h_rt;
    logic                  is_mfhi, is_mflo, h_mfhi, h_mflo;
    logic [DATA_WIDTH-1:0] rs_val, rt_val, hi_val, lo_val;
    logic                  capture;

    assign rs      = in_instr[21 +: ADDR_WIDTH];
    assign rt      = in_instr[16 +: ADDR_WIDTH];
    assign is_mfhi = (in_instr[31:26] == 6'd0) && (in_instr[5:0] == 6'b010000);
    assign is_mflo = (in_instr[31:26] == 6'd0) && (in_instr[5:0] == 6'b010010);

    assign h_rs    = out_instr_q[21 +: ADDR_WIDTH];
    assign h_rt    = out_instr_q[16 +: ADDR_WIDTH];
    assign h_mfhi  = (out_instr_q[31:26] == 6'd0) && (out_instr_q[5:0] == 6'b010000);
    assign h_mflo  = (out_instr_q[31:26] == 6'd0) && (out_instr_q[5:0] == 6'b010010);

    // Write-first reads: a same-cycle writeback is visible to the capturing instruction.
    assign rs_val = (rs == '0) ? '0 : (wb_en && wb_addr == rs) ? wb_data : gpr_q[rs];
    assign rt_val = (rt == '0) ? '0 : (wb_en && wb_addr == rt) ? wb_data : gpr_q[rt];
    assign hi_val = hilo_we ? hi_wdata : hi_q;
    assign lo_val = hilo_we ? lo_wdata : lo_q;

    assign in_ready = !flush && (!out_valid_q || out_ready);
    assign capture  = in_valid && in_ready;

    always_comb begin
        out_valid_d = out_valid_q;
        out_instr_d = out_instr_q;
        out_in0_d   = out_in0_q;
        out_in1_d   = out_in1_q;
        if (flush) begin
            out_valid_d = 1'b0;
        end else if (capture) begin
            out_valid_d = 1'b1;
            out_instr_d = in_instr;
            out_in0_d   = is_mfhi ? hi_val : is_mflo ? lo_val : rs_val;
            out_in1_d   = rt_val;
        end else if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end else if (out_valid_q) begin
            // Stalled entry tracks writebacks so it never presents a stale operand.
            if (h_mfhi) begin
                if (hilo_we) out_in0_d = hi_wdata;
            end else if (h_mflo) begin
                if (hilo_we) out_in0_d = lo_wdata;
            end else if (wb_en && h_rs != '0 && wb_addr == h_rs) begin
                out_in0_d = wb_data;
            end
            if (wb_en && h_rt != '0 && wb_addr == h_rt) out_in1_d = wb_data;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid_q <= 1'b0;
            out_instr_q <= '0;
            out_in0_q   <= '0;
            out_in1_q   <= '0;
            hi_q        <= '0;
            lo_q        <= '0;
            for (int unsigned i = 0; i < NREG; i++) gpr_q[i] <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            out_instr_q <= out_instr_d;
            out_in0_q   <= out_in0_d;
            out_in1_q   <= out_in1_d;
            if (wb_en && wb_addr != '0) gpr_q[wb_addr] <= wb_data;
            if (hilo_we) begin
                hi_q <= hi_wdata;
                lo_q <= lo_wdata;
            end
        end
    end

    assign out_valid = out_valid_q;
    assign out_instr = out_instr_q;
    assign out_in0   = out_in0_q;
    assign out_in1   = out_in1_q;

endmodule

// File: tb/tb_operand_fetch_stage.sv
// Scoreboard bench for operand_fetch_stage: a reference GPR/HI/LO model pushes the
// expected ALU operands at capture and the held entry is compared every cycle until consumed.
module tb_operand_fetch_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid, in_ready, out_valid, out_ready, flush;
    logic [31:0] in_instr, out_instr, out_in0, out_in1;
    logic        wb_en, hilo_we;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data, hi_wdata, lo_wdata;

    operand_fetch_stage #(.DATA_WIDTH(32), .ADDR_WIDTH(5)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr),
        .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr),
        .out_in0(out_in0), .out_in1(out_in1), .flush(flush),
        .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
        .hilo_we(hilo_we), .hi_wdata(hi_wdata), .lo_wdata(lo_wdata)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] in0;
        logic [31:0] in1;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] m_gpr [32];
    logic [31:0] m_hi, m_lo;
    int          n_checks = 0;
    int          n_fail   = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] m_rd(input logic [4:0] idx, input logic we,
                                         input logic [4:0] wa, input logic [31:0] wd);
        if (idx == 5'd0) return 32'd0;
        if (we && wa == idx) return wd;
        return m_gpr[idx];
    endfunction

    function automatic logic is_fn(input logic [31:0] ins, input logic [5:0] fn);
        return ins[31:26] == 6'd0 && ins[5:0] == fn;
    endfunction

    task automatic model_reset();
        sb.delete();
        for (int i = 0; i < 32; i++) m_gpr[i] = 32'd0;
        m_hi = 32'd0;
        m_lo = 32'd0;
    endtask

    task automatic step(input logic iv, input logic [31:0] ins, input logic ordy, input logic fl,
                        input logic we, input logic [4:0] wa, input logic [31:0] wd,
                        input logic hwe, input logic [31:0] hw, input logic [31:0] lw);
        logic mv, rdy;
        exp_t e, h;
        @(negedge clk);
        in_valid = iv; in_instr = ins; out_ready = ordy; flush = fl;
        wb_en = we; wb_addr = wa; wb_data = wd; hilo_we = hwe; hi_wdata = hw; lo_wdata = lw;
        #1;
        mv = sb.size() != 0;
        chk("out_valid", {31'd0, out_valid}, {31'd0, mv});
        if (mv) begin
            chk("out_instr", out_instr, sb[0].instr);
            chk("out_in0", out_in0, sb[0].in0);
            chk("out_in1", out_in1, sb[0].in1);
        end
        rdy = !fl && (!mv || ordy);
        chk("in_ready", {31'd0, in_ready}, {31'd0, rdy});
        @(posedge clk);
        e.instr = ins;
        e.in1   = m_rd(ins[20:16], we, wa, wd);
        if (is_fn(ins, 6'b010000))      e.in0 = hwe ? hw : m_hi;
        else if (is_fn(ins, 6'b010010)) e.in0 = hwe ? lw : m_lo;
        else                            e.in0 = m_rd(ins[25:21], we, wa, wd);
        if (fl) sb.delete();
        else if (mv && ordy) void'(sb.pop_front());
        else if (mv) begin
            h = sb[0];
            if (is_fn(h.instr, 6'b010000)) begin
                if (hwe) h.in0 = hw;
            end else if (is_fn(h.instr, 6'b010010)) begin
                if (hwe) h.in0 = lw;
            end else if (we && wa != 5'd0 && wa == h.instr[25:21]) h.in0 = wd;
            if (we && wa != 5'd0 && wa == h.instr[20:16]) h.in1 = wd;
            sb[0] = h;
        end
        if (iv && rdy) sb.push_back(e);
        if (we && wa != 5'd0) m_gpr[wa] = wd;
        if (hwe) begin m_hi = hw; m_lo = lw; end
    endtask

    task automatic idle(input logic ordy);
        step(1'b0, 32'd0, ordy, 1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 32'd0, 32'd0);
    endtask

    initial begin
        logic [31:0] ri;
        logic [4:0]  a;
        reset = 1'b1;
        in_valid = 0; in_instr = 0; out_ready = 0; flush = 0;
        wb_en = 0; wb_addr = 0; wb_data = 0; hilo_we = 0; hi_wdata = 0; lo_wdata = 0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_instr", out_instr, 32'd0);
        chk("rst_in0", out_in0, 32'd0);
        chk("rst_in1", out_in1, 32'd0);
        @(negedge clk) reset = 1'b0;

        // Basic capture, then same-cycle GPR bypass.
        step(0, 32'd0, 1, 0, 1, 5'd1, 32'hDDDDDDDD, 0, 0, 0);
        step(1, 32'h00011040, 1, 0, 0, 0, 0, 0, 0, 0);
        step(1, 32'h1443FFFF, 1, 0, 1, 5'd2, 32'h00000003, 0, 0, 0);

        // Stall with refresh of rt, blocked capture, then consume.
        idle(0);
        step(1, 32'h00A52820, 0, 0, 1, 5'd3, 32'h00004001, 0, 0, 0);
        idle(0);
        idle(1);
        idle(1);

        // rs==rt refresh, and a write to r0 during stall.
        step(1, 32'h00A52820, 1, 0, 0, 0, 0, 0, 0, 0);
        step(0, 32'd0, 0, 0, 1, 5'd5, 32'h00000055, 0, 0, 0);
        step(0, 32'd0, 0, 0, 1, 5'd0, 32'hFFFFFFFF, 0, 0, 0);
        idle(1);

        // HI/LO: mfhi, mflo, stalled refresh of mflo, bypass of mflo.
        step(0, 32'd0, 1, 0, 0, 0, 0, 1, 32'h12345678, 32'h9ABCDEF0);
        step(1, 32'h00001010, 1, 0, 0, 0, 0, 0, 0, 0);
        step(1, 32'h00001012, 1, 0, 0, 0, 0, 0, 0, 0);
        step(1, 32'h00001010, 0, 0, 0, 0, 0, 1, 32'hAAAA0001, 32'hBBBB0002);
        idle(1);
        step(1, 32'h00001012, 1, 0, 0, 0, 0, 1, 32'h00000011, 32'h00000022);
        idle(1);

        // Full-throughput stream, then flush with an incoming instruction.
        for (int i = 0; i < 4; i++) begin
            a = 5'(i + 1);
            step(1, {6'd0, a, a + 5'd1, 16'h0020}, 1, 0, 1, 5'(i + 6), 32'(i * 7 + 1), 0, 0, 0);
        end
        step(1, 32'h00221820, 1, 1, 1, 5'd9, 32'h99, 0, 0, 0);
        idle(1);

        // Randomised traffic against the model.
        for (int i = 0; i < 300; i++) begin
            ri = {6'd0, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 10'd0, 6'h20};
            case ($urandom_range(0, 9))
                0: ri[5:0] = 6'b010000;
                1: ri[5:0] = 6'b010010;
                default: ;
            endcase
            step($urandom_range(0, 3) != 0, ri, $urandom_range(0, 9) < 7, $urandom_range(0, 9) == 0,
                 $urandom_range(0, 1) == 1, 5'($urandom_range(0, 7)), $urandom,
                 $urandom_range(0, 4) == 0, $urandom, $urandom);
        end
        idle(1);

        // Asynchronous reset during a stall.
        step(1, 32'h00611820, 1, 0, 0, 0, 0, 0, 0, 0);
        idle(0);
        @(negedge clk);
        in_valid = 0; out_ready = 0; flush = 0; wb_en = 0; hilo_we = 0;
        reset = 1'b1;
        #1;
        chk("arst_valid", {31'd0, out_valid}, 32'd0);
        chk("arst_instr", out_instr, 32'd0);
        chk("arst_in0", out_in0, 32'd0);
        chk("arst_in1", out_in1, 32'd0);
        model_reset();
        @(negedge clk) reset = 1'b0;
        step(0, 32'd0, 1, 0, 1, 5'd0, 32'hFFFFFFFF, 0, 0, 0);
        step(1, 32'h00031820, 1, 0, 0, 0, 0, 0, 0, 0);
        step(1, 32'h00001010, 1, 0, 0, 0, 0, 0, 0, 0);
        idle(1);
        idle(1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
